multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
Multi-cycle sequencer for the 64-bit RISC-V datapath: PC, instruction register, register file, ALU, data memory. It replaces the single-cycle control with an IDLE/IF/ID/EX/MEM/WB state machine. Instruction and data memories sit behind req/ready handshakes with a wait timeout. The datapath muxes, PC register, IR and old-PC register are driven from this block's strobes.

Parameters:
TIMEOUT_CYCLES, 16, max consecutive cycles a memory req may wait for ready; 0 disables the timeout
WAIT_W, 8, width of the wait counter; must satisfy 2**WAIT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
opcode  in  7  IR[6:0], stable from the cycle after IRWrite
Zero  in  1  ALU zero flag, valid in EX
imem_ready  in  1  instruction memory data valid
dmem_ready  in  1  data memory access complete
imem_req  out  1  instruction fetch request
dmem_req  out  1  data memory request
MemRead / MemWrite  out  1 each  data memory direction, valid with dmem_req
IRWrite  out  1  load IR and old-PC register
PCWrite  out  1  load PC
PCSrc  out  1  0 = PC+4, 1 = old-PC + (imm<<1)
RegWrite  out  1  register file write strobe
MemtoReg  out  1  writeback select, 1 = memory data
ALUSrc  out  1  1 = immediate operand
ALUOp  out  2  00 add, 01 subtract, 10 funct-decoded
instr_done  out  1  one-cycle pulse on instruction retire
error  out  1  sticky fault flag
state  out  3  current state, for debug

Behaviour:
- Reset, asynchronous, any state, mid-handshake included: state goes to IDLE, wait counter 0, latched class cleared. Every output is 0 while reset is high and in IDLE.
- IDLE -> IF unconditionally on the next edge.
- Outputs are Moore decodes of state and latched class. The exceptions are IRWrite, PCWrite, PCSrc, dmem-complete and instr_done, which also qualify on the ready and Zero inputs as noted below.
- IF:
  - imem_req=1.
  - On imem_ready: IRWrite=1, PCWrite=1, PCSrc=0, go to ID.
  - Otherwise stay in IF and increment the wait counter.
- ID:
  - Decode opcode into a registered class: R (0110011), I (0010011), LD (0000011), ST (0100011), BEQ (1100011).
  - Legal opcode -> EX. Any other opcode -> ERR.
- EX:
  - ALUSrc=1 for I, LD and ST.
  - ALUOp: 10 for R and I, 00 for LD and ST, 01 for BEQ.
  - BEQ: PCWrite=Zero, PCSrc=Zero, instr_done=1, go to IF.
  - R and I go to WB. LD and ST go to MEM.
- MEM:
  - dmem_req=1. MemRead=1 for LD, MemWrite=1 for ST. ALUSrc and ALUOp are held from EX.
  - On dmem_ready: ST gives instr_done=1 and goes to IF. LD goes to WB.
- WB: RegWrite=1, MemtoReg=1 for LD, instr_done=1, go to IF.
- Zero-wait latencies: BEQ 3 cycles, R/I/ST 4 cycles, LD 5 cycles.
- Wait counter:
  - Clears on every state change.
  - Counts cycles in IF/MEM with req high and ready low.
  - If TIMEOUT_CYCLES>0, the counter equals TIMEOUT_CYCLES-1 and ready is low, go to ERR.
  - ready in the same cycle as that limit wins; the access completes normally.
- ERR: all strobes 0, error=1, and ERR holds until reset. No PC or register-file write ever occurs in or after ERR.
- Requests are held high until ready; req never deasserts mid-handshake except on reset or timeout.

Optional Feature:
PERF_COUNTERS_EN
- Defined: adds output ports cycle_count[63:0] and instret[63:0], both reset to 0.
  - cycle_count increments every cycle the state is not IDLE or ERR.
  - instret increments on each instr_done.
  - Both wrap modulo 2^64.
- Undefined: the ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum: IDLE=0, IF=1, ID=2, EX=3, MEM=4, WB=5, ERR=6
  - opcode constants
  - instruction-class enum
  - ALUOp codes
- One sub-module, mem_wait_timer: counter with clear, enable and limit, producing a timeout pulse. It is instantiated once and shared by IF and MEM.

Test Plan:
- add, opcode 0110011, zero-wait memories -> states IF,ID,EX,WB. ALUOp=10 in EX, RegWrite=1 in WB, instr_done in cycle 4.
- ld, opcode 0000011, dmem_ready delayed 3 cycles -> dmem_req and MemRead high for 4 cycles in MEM. Then WB with MemtoReg=1; 8 cycles total.
- beq:
  - Zero=1 -> PCWrite=1 and PCSrc=1 in EX, retire in 3 cycles.
  - Zero=0 -> PCWrite=0 in EX.
- opcode 1111111 -> ERR after ID, error=1. Holds ERR for 20 cycles with all strobes 0; reset returns to IDLE.
- Timeout, TIMEOUT_CYCLES=4, imem_ready never asserted -> ERR on the 4th IF cycle. Repeat with imem_ready in cycle 4 -> proceeds to ID.
- Reset pulsed mid-MEM of an sd -> all outputs 0 immediately, no MemWrite after release, IDLE then IF. With PERF_COUNTERS_EN, cycle_count and instret read 0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle RISC-V control unit.
//   state_t        : sequencer states, encoding visible on the debug 'state' port
//   instr_class_t  : instruction class latched during ID
//   OPC_*          : major opcodes recognised by the decoder
//   ALUOP_*        : ALUOp codes driven to the ALU control
//   decode_class() : opcode -> instruction class (CLS_NONE for unsupported opcodes)
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_IF   = 3'd1,
    ST_ID   = 3'd2,
    ST_EX   = 3'd3,
    ST_MEM  = 3'd4,
    ST_WB   = 3'd5,
    ST_ERR  = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_R    = 3'd1,
    CLS_I    = 3'd2,
    CLS_LD   = 3'd3,
    CLS_ST   = 3'd4,
    CLS_BEQ  = 3'd5
  } instr_class_t;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LD  = 7'b0000011;
  localparam logic [6:0] OPC_ST  = 7'b0100011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  function automatic instr_class_t decode_class(input logic [6:0] opc);
    instr_class_t cls;
    case (opc)
      OPC_R:   cls = CLS_R;
      OPC_I:   cls = CLS_I;
      OPC_LD:  cls = CLS_LD;
      OPC_ST:  cls = CLS_ST;
      OPC_BEQ: cls = CLS_BEQ;
      default: cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter shared by the instruction-fetch and data-memory handshakes.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clear      : zero the counter (has priority over enable)
//   enable     : a request is pending and ready is low this cycle
//   timeout    : combinational pulse, high when the current waiting cycle is the
//                LIMIT-th consecutive one; never asserted when LIMIT == 0
module mem_wait_timer #(
  parameter int unsigned LIMIT  = 16,
  parameter int unsigned WAIT_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam logic [WAIT_W-1:0] LAST = (LIMIT > 0) ? WAIT_W'(LIMIT - 1) : '0;

  logic [WAIT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign timeout = (LIMIT != 0) && enable && (count == LAST);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer (IDLE/IF/ID/EX/MEM/WB/ERR) for the 64-bit RISC-V datapath.
// Ports:
//   clk, reset               : clock, asynchronous active-high reset
//   opcode                   : IR[6:0]
//   Zero                     : ALU zero flag, sampled in EX for BEQ
//   imem_ready / dmem_ready  : memory handshake completions
//   imem_req / dmem_req      : memory requests, held until ready, timeout or reset
//   MemRead / MemWrite       : data memory direction
//   IRWrite, PCWrite, PCSrc  : IR/old-PC load, PC load, PC source (1 = branch target)
//   RegWrite, MemtoReg       : register file write strobe and writeback select
//   ALUSrc, ALUOp            : ALU operand select and operation class
//   instr_done               : one-cycle retire pulse
//   error                    : sticky fault flag, cleared only by reset
//   state                    : current state, for debug
// Optional feature (macro PERF_COUNTERS_EN): adds cycle_count and instret outputs.
module multicycle_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned WAIT_W         = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        Zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic        RegWrite,
  output logic        MemtoReg,
  output logic        ALUSrc,
  output logic [1:0]  ALUOp,
  output logic        instr_done,
  output logic        error,
  output logic [2:0]  state
`ifdef PERF_COUNTERS_EN
  ,
  output logic [63:0] cycle_count,
  output logic [63:0] instret
`endif
);

  state_t       state_q, state_d;
  instr_class_t cls_q, cls_d;
  logic         wait_en;
  logic         timeout;

  // Kept outside the decode block so the timer's timeout does not feed back
  // into the process that produces its enable.
  assign wait_en = ((state_q == ST_IF)  && !imem_ready) ||
                   ((state_q == ST_MEM) && !dmem_ready);

  mem_wait_timer #(
    .LIMIT  (TIMEOUT_CYCLES),
    .WAIT_W (WAIT_W)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_d != state_q),
    .enable  (wait_en),
    .timeout (timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cls_q   <= CLS_NONE;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    PCSrc      = 1'b0;
    RegWrite   = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrc     = 1'b0;
    ALUOp      = ALUOP_ADD;
    instr_done = 1'b0;
    error      = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_IF;

      ST_IF: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = ST_ID;
        end else if (timeout) begin
          state_d = ST_ERR;
        end
      end

      ST_ID: begin
        cls_d   = decode_class(opcode);
        state_d = (cls_d == CLS_NONE) ? ST_ERR : ST_EX;
      end

      ST_EX: begin
        ALUSrc = (cls_q == CLS_I) || (cls_q == CLS_LD) || (cls_q == CLS_ST);
        case (cls_q)
          CLS_R, CLS_I: begin
            ALUOp   = ALUOP_FUNCT;
            state_d = ST_WB;
          end
          CLS_LD, CLS_ST: begin
            ALUOp   = ALUOP_ADD;
            state_d = ST_MEM;
          end
          CLS_BEQ: begin
            ALUOp      = ALUOP_SUB;
            PCWrite    = Zero;
            PCSrc      = Zero;
            instr_done = 1'b1;
            state_d    = ST_IF;
          end
          default: state_d = ST_ERR;
        endcase
      end

      ST_MEM: begin
        dmem_req = 1'b1;
        MemRead  = (cls_q == CLS_LD);
        MemWrite = (cls_q == CLS_ST);
        ALUSrc   = 1'b1;
        ALUOp    = ALUOP_ADD;
        if (dmem_ready) begin
          if (cls_q == CLS_ST) begin
            instr_done = 1'b1;
            state_d    = ST_IF;
          end else begin
            state_d = ST_WB;
          end
        end else if (timeout) begin
          state_d = ST_ERR;
        end
      end

      ST_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = (cls_q == CLS_LD);
        instr_done = 1'b1;
        state_d    = ST_IF;
      end

      ST_ERR: error = 1'b1;

      default: begin
        error   = 1'b1;
        state_d = ST_ERR;
      end
    endcase
  end

  assign state = state_q;

`ifdef PERF_COUNTERS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count <= '0;
      instret     <= '0;
    end else begin
      if ((state_q != ST_IDLE) && (state_q != ST_ERR)) begin
        cycle_count <= cycle_count + 64'd1;
      end
      if (instr_done) begin
        instret <= instret + 64'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit (TIMEOUT_CYCLES = 4).
// Each instruction is expanded into an expected state timeline from its class
// and memory delays; strobes are checked as per-instruction totals plus
// point checks in EX/WB and on the retire cycle.
`timescale 1ns/1ps
module tb_multicycle_control_unit;

  localparam int unsigned T = 4;

  localparam int S_IDLE = 0;
  localparam int S_IF   = 1;
  localparam int S_ID   = 2;
  localparam int S_EX   = 3;
  localparam int S_MEM  = 4;
  localparam int S_WB   = 5;
  localparam int S_ERR  = 6;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic        Zero, imem_ready, dmem_ready;
  logic        imem_req, dmem_req, MemRead, MemWrite, IRWrite, PCWrite, PCSrc;
  logic        RegWrite, MemtoReg, ALUSrc, instr_done, error;
  logic [1:0]  ALUOp;
  logic [2:0]  state;
`ifdef PERF_COUNTERS_EN
  logic [63:0] cycle_count, instret;
`endif

  int n_checks = 0;
  int n_errors = 0;
  longint unsigned m_cycles = 0;
  longint unsigned m_instret = 0;

  multicycle_control_unit #(
    .TIMEOUT_CYCLES (T),
    .WAIT_W         (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .Zero       (Zero),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .imem_req   (imem_req),
    .dmem_req   (dmem_req),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .PCSrc      (PCSrc),
    .RegWrite   (RegWrite),
    .MemtoReg   (MemtoReg),
    .ALUSrc     (ALUSrc),
    .ALUOp      (ALUOp),
    .instr_done (instr_done),
    .error      (error),
    .state      (state)
`ifdef PERF_COUNTERS_EN
    ,
    .cycle_count (cycle_count),
    .instret     (instret)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] strobes();
    return {imem_req, dmem_req, MemRead, MemWrite, IRWrite, PCWrite, PCSrc,
            RegWrite, MemtoReg, ALUSrc, ALUOp, instr_done};
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LD) || (op == OP_ST) || (op == OP_BEQ);
  endfunction

  function automatic int unsigned pick_delay();
    if ($urandom_range(0, 11) == 0) return T + $urandom_range(0, 2);
    return $urandom_range(0, T - 1);
  endfunction

  task automatic randomize_inputs();
    opcode     = 7'($urandom);
    Zero       = 1'($urandom);
    imem_ready = 1'($urandom);
    dmem_ready = 1'($urandom);
  endtask

  task automatic check_perf(input string tag);
`ifdef PERF_COUNTERS_EN
    check_eq({tag, "_cycle_count"}, cycle_count, m_cycles);
    check_eq({tag, "_instret"}, instret, m_instret);
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    randomize_inputs();
    #1;
    m_cycles  = 0;
    m_instret = 0;
    check_eq("rst_state", state, S_IDLE);
    check_eq("rst_strobes", strobes(), 0);
    check_eq("rst_error", error, 1'b0);
    check_perf("rst");
    @(negedge clk);
    reset = 1'b0;
    randomize_inputs();
    #1;
    check_eq("idle_state", state, S_IDLE);
    check_eq("idle_strobes", strobes(), 0);
    check_eq("idle_error", error, 1'b0);
  endtask

  task automatic hold_err(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      randomize_inputs();
      #1;
      check_eq("err_state", state, S_ERR);
      check_eq("err_flag", error, 1'b1);
      check_eq("err_strobes", strobes(), 0);
      if (i == n - 1) check_perf("err");
    end
  endtask

  task automatic run_instr(input logic [6:0] op, input int unsigned di, input int unsigned dd,
                           input logic z, input int unsigned err_cycles);
    int st_q[$];
    int k_q[$];
    bit is_r, is_i, is_ld, is_st, is_beq, legal, reached_ex, to_err, in_wb;
    int unsigned ifc, mc;
    int o_ireq, o_irw, o_pcw, o_pcsel, o_dreq, o_mrd, o_mwr, o_asmem, o_rw, o_m2r, o_done, o_err;
    int cur;

    is_r   = (op == OP_R);
    is_i   = (op == OP_I);
    is_ld  = (op == OP_LD);
    is_st  = (op == OP_ST);
    is_beq = (op == OP_BEQ);
    legal  = is_legal(op);
    reached_ex = (di < T) && legal;
    to_err = 1'b0;
    in_wb  = 1'b0;
    mc     = 0;

    ifc = (di >= T) ? T : di + 1;
    for (int unsigned k = 0; k < ifc; k++) begin
      st_q.push_back(S_IF);
      k_q.push_back(int'(k));
    end
    if (di >= T) begin
      to_err = 1'b1;
    end else begin
      st_q.push_back(S_ID);
      k_q.push_back(0);
      if (!legal) begin
        to_err = 1'b1;
      end else begin
        st_q.push_back(S_EX);
        k_q.push_back(0);
        if (is_ld || is_st) begin
          mc = (dd >= T) ? T : dd + 1;
          for (int unsigned k = 0; k < mc; k++) begin
            st_q.push_back(S_MEM);
            k_q.push_back(int'(k));
          end
          if (dd >= T) to_err = 1'b1;
          else if (is_ld) in_wb = 1'b1;
        end else if (!is_beq) begin
          in_wb = 1'b1;
        end
        if (in_wb) begin
          st_q.push_back(S_WB);
          k_q.push_back(0);
        end
      end
    end

    o_ireq = 0; o_irw = 0; o_pcw = 0; o_pcsel = 0; o_dreq = 0; o_mrd = 0;
    o_mwr = 0; o_asmem = 0; o_rw = 0; o_m2r = 0; o_done = 0; o_err = 0;

    for (int c = 0; c < st_q.size(); c++) begin
      cur = st_q[c];
      @(negedge clk);
      opcode     = (cur == S_IF)  ? 7'($urandom) : op;
      Zero       = (cur == S_EX)  ? z : 1'($urandom);
      imem_ready = (cur == S_IF)  ? (k_q[c] == int'(di)) : 1'($urandom);
      dmem_ready = (cur == S_MEM) ? (k_q[c] == int'(dd)) : 1'($urandom);
      #1;
      check_eq("state", state, cur);
      o_ireq  += int'(imem_req);
      o_irw   += int'(IRWrite);
      o_pcw   += int'(PCWrite);
      o_pcsel += int'(PCWrite && PCSrc);
      o_dreq  += int'(dmem_req);
      o_mrd   += int'(MemRead);
      o_mwr   += int'(MemWrite);
      o_asmem += int'(dmem_req && ALUSrc && (ALUOp == 2'b00));
      o_rw    += int'(RegWrite);
      o_m2r   += int'(RegWrite && MemtoReg);
      o_done  += int'(instr_done);
      o_err   += int'(error);
      if (cur == S_EX) begin
        check_eq("ex_ALUOp", ALUOp, (is_r || is_i) ? 2'b10 : (is_beq ? 2'b01 : 2'b00));
        check_eq("ex_ALUSrc", ALUSrc, is_i || is_ld || is_st);
        if (is_beq) begin
          check_eq("beq_PCWrite", PCWrite, z);
          check_eq("beq_PCSrc", PCSrc, z);
        end
      end
      if (cur == S_WB) check_eq("wb_MemtoReg", MemtoReg, is_ld);
      if (c == st_q.size() - 1) begin
        check_eq("retire_pulse", instr_done, !to_err);
        check_perf("instr");
        if (!to_err) m_instret++;
      end
      m_cycles++;
    end

    check_eq("cnt_imem_req", o_ireq, ifc);
    check_eq("cnt_IRWrite", o_irw, di < T);
    check_eq("cnt_PCWrite", o_pcw, int'(di < T) + int'(reached_ex && is_beq && z));
    check_eq("cnt_PCSrc", o_pcsel, reached_ex && is_beq && z);
    check_eq("cnt_dmem_req", o_dreq, mc);
    check_eq("cnt_MemRead", o_mrd, is_ld ? mc : 0);
    check_eq("cnt_MemWrite", o_mwr, is_st ? mc : 0);
    check_eq("cnt_mem_alu", o_asmem, mc);
    check_eq("cnt_RegWrite", o_rw, in_wb);
    check_eq("cnt_MemtoReg", o_m2r, in_wb && is_ld);
    check_eq("cnt_instr_done", o_done, !to_err);
    check_eq("cnt_error", o_err, 0);

    if (to_err) begin
      hold_err(err_cycles);
      do_reset();
    end
  endtask

  task automatic reset_mid_store();
    int seq[5];
    seq = '{S_IF, S_ID, S_EX, S_MEM, S_MEM};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      opcode     = OP_ST;
      imem_ready = (c == 0);
      dmem_ready = 1'b0;
      Zero       = 1'b0;
      #1;
      check_eq("sd_state", state, seq[c]);
    end
    check_eq("sd_MemWrite", MemWrite, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    m_cycles  = 0;
    m_instret = 0;
    check_eq("midrst_state", state, S_IDLE);
    check_eq("midrst_strobes", strobes(), 0);
    check_eq("midrst_error", error, 1'b0);
    check_perf("midrst");
    @(negedge clk);
    reset      = 1'b0;
    dmem_ready = 1'b1;
    #1;
    check_eq("postrst_state", state, S_IDLE);
    check_eq("postrst_strobes", strobes(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] op;
    logic [6:0] legal_ops [5];
    legal_ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BEQ};
    reset = 1'b1;
    opcode = '0;
    Zero = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    do_reset();

    run_instr(OP_R,   0, 0, 1'b0, 1);
    run_instr(OP_LD,  0, 3, 1'b0, 1);
    run_instr(OP_BEQ, 0, 0, 1'b1, 1);
    run_instr(OP_BEQ, 0, 0, 1'b0, 1);
    run_instr(OP_ST,  1, 2, 1'b0, 1);
    run_instr(OP_I,   2, 0, 1'b1, 1);
    run_instr(7'b1111111, 0, 0, 1'b0, 20);
    run_instr(OP_R,   T, 0, 1'b0, 3);
    run_instr(OP_R,   T - 1, 0, 1'b0, 1);
    run_instr(OP_LD,  0, T, 1'b0, 3);
    reset_mid_store();
    run_instr(OP_ST,  0, 0, 1'b0, 1);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        op = 7'($urandom);
        while (is_legal(op)) op = 7'($urandom);
      end else begin
        op = legal_ops[$urandom_range(0, 4)];
      end
      run_instr(op, pick_delay(), pick_delay(), 1'($urandom), $urandom_range(1, 6));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
